// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmitter (and later the receiver).
// UART_TX_PARITY_EN selects an 11-bit frame carrying an even-parity bit.
package uart_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        TRANSMIT = 1'b1
    } tx_state_t;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned FRAME_BITS = 11;
`else
    localparam int unsigned FRAME_BITS = 10;
`endif

    localparam int unsigned BAUD_DIV_19200 = 2604;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: pulses shift on the last clock of each BAUD_DIV-cycle period.
// PRELOAD_HALF makes clr load half a period, for a receiver sampling mid-bit.
module uart_baud_cnt #(
    parameter int unsigned BAUD_DIV     = 2604,
    parameter bit          PRELOAD_HALF = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic shift
);

    localparam int unsigned CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] LAST  = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] START = PRELOAD_HALF ? CW'(BAUD_DIV / 2) : '0;

    logic [CW-1:0] r_cnt;

    // Wraps to zero on the same cycle shift is asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= START;
        end else if (en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CW'(1);
        end
    end

    assign shift = en && (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter; TX comes straight from bit 0 of the shift register.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = BAUD_DIV_19200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       trmt,
    input  logic [7:0] tx_data,
    output logic       TX,
    output logic       tx_done
);

    localparam int unsigned SR_W = FRAME_BITS - 1;

    tx_state_t       r_state;
    logic [SR_W-1:0] r_shift;
    logic [3:0]      r_bit_cnt;
    logic            r_done;

    logic            w_load;
    logic            w_en;
    logic            w_shift;
    logic            w_last;
    logic [SR_W-1:0] w_load_val;

    assign w_load = (r_state == IDLE) && trmt;
    assign w_en   = (r_state == TRANSMIT);
    // The final shift moves the stop bit out; a 1 fills in, so the line stays high.
    assign w_last = w_shift && (r_bit_cnt == 4'(FRAME_BITS - 1));

`ifdef UART_TX_PARITY_EN
    assign w_load_val = {^tx_data, tx_data, 1'b0};
`else
    assign w_load_val = {tx_data, 1'b0};
`endif

    uart_baud_cnt #(
        .BAUD_DIV     (BAUD_DIV),
        .PRELOAD_HALF (1'b0)
    ) u_baud_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_load),
        .en    (w_en),
        .shift (w_shift)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_shift   <= '1;
            r_bit_cnt <= 4'd0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (trmt) begin
                        r_state   <= TRANSMIT;
                        r_shift   <= w_load_val;
                        r_bit_cnt <= 4'd0;
                        r_done    <= 1'b0;
                    end
                end
                TRANSMIT: begin
                    if (w_shift) begin
                        r_shift   <= {1'b1, r_shift[SR_W-1:1]};
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign TX      = r_shift[0];
    assign tx_done = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: every clock is compared against a frame model
// built from the byte (start, data LSB first, optional parity, stop).
module tb_uart_tx;

    localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;

    int n_tests = 0;
    int n_fail  = 0;

    uart_tx #(.BAUD_DIV(BD)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int t, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0b expected=%0b", tag, t, obs, exp);
        end
    endtask

    // Level of frame bit idx for byte d.
    function automatic logic frame_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9) return ^d;
`endif
        return 1'b1;
    endfunction

    // Idle line for n cycles; tx_done must hold its value.
    task automatic idle(input int n, input logic exp_done);
        for (int t = 0; t < n; t++) begin
            @(negedge clk);
            trmt    = 1'b0;
            tx_data = 8'($urandom);
            check("idle_tx", t, TX, 1'b1);
            check("idle_done", t, tx_done, exp_done);
        end
    endtask

    // Called at a negedge: present d, then check every cycle through the done edge.
    // t counts negedges after accept edge k; inj_t >= 0 pulses trmt again mid-frame.
    task automatic frame(input logic [7:0] d, input int inj_t, input logic [7:0] inj_d);
        trmt    = 1'b1;
        tx_data = d;
        for (int t = 0; t <= NB * BD; t++) begin
            @(negedge clk);
            trmt    = (t == inj_t);
            tx_data = (t == inj_t) ? inj_d : 8'($urandom);
            check("frame_tx", t, TX, (t < NB * BD) ? frame_bit(d, t / BD) : 1'b1);
            check("frame_done", t, tx_done, (t >= NB * BD));
        end
    endtask

    initial begin
        logic [7:0] d;
        int         inj;

        rst_n   = 1'b0;
        trmt    = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_tx", 0, TX, 1'b1);
        check("reset_done", 0, tx_done, 1'b0);
        rst_n = 1'b1;
        idle(5 * BD, 1'b0);

        frame(8'hA5, -1, 8'h00);
        idle(2 * BD, 1'b1);

        // Second trmt sampled at edge k+40 must be ignored.
        frame(8'h3C, 39, 8'hFF);
        idle(BD, 1'b1);

        // Back-to-back: next trmt sampled in the first idle cycle.
        frame(8'h00, -1, 8'h00);
        frame(8'hFF, -1, 8'h00);
        frame(8'h07, -1, 8'h00);

        // Reset asserted between edges mid-frame, while TX is low.
        trmt    = 1'b1;
        tx_data = 8'h00;
        for (int t = 0; t < 70; t++) begin
            @(negedge clk);
            trmt    = 1'b0;
            tx_data = 8'($urandom);
            check("abort_pre_tx", t, TX, frame_bit(8'h00, t / BD));
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_async_tx", 70, TX, 1'b1);
        check("abort_async_done", 70, tx_done, 1'b0);
        repeat (2) begin
            @(negedge clk);
            check("abort_hold_tx", 71, TX, 1'b1);
        end
        rst_n = 1'b1;
        idle(2 * BD, 1'b0);
        frame(8'h55, -1, 8'h00);
        idle(BD, 1'b1);

        // Random bytes, random ignored re-triggers, random gaps.
        for (int i = 0; i < 10; i++) begin
            d   = 8'($urandom);
            inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB * BD - 1)) : -1;
            frame(d, inj, 8'($urandom));
            if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 20)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial transmitter for 8N1 UART frames: 1 start bit (low), 8 data bits LSB first, 1 stop bit (high).
- Companion to the existing UART receiver. Same baud arithmetic: 50 MHz clk, 19200 baud, 2604 clocks per bit.
- Sits in the remote-comm path. The command/response logic presents a byte and pulses trmt; the block serializes it onto TX and flags completion.

Parameters:
- BAUD_DIV, 2604, clocks per bit period (50 MHz / 19200); must be >= 4; baud counter width derived as $clog2(BAUD_DIV)

Ports:
- clk  input  1  system clock, 50 MHz
- rst_n  input  1  asynchronous active-low reset
- trmt  input  1  single-cycle pulse; start transmitting tx_data
- tx_data  input  8  byte to send; sampled only on the cycle trmt is accepted
- TX  output  1  serial line; idles high
- tx_done  output  1  high when the last frame has completed; stays high until the next accepted trmt

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All flops reset asynchronously.
- Reset values:
  - TX = 1.
  - Shift register = all ones (9'h1FF).
  - tx_done = 0.
  - State = IDLE.
  - Baud and bit counters = 0.
- Datapath:
  - 9-bit shift register. On load it takes {tx_data, 1'b0}.
  - On each shift it moves right and fills the MSB with 1.
  - TX is driven directly from bit 0 of the shift register (registered, glitch-free).
- Baud counter:
  - Loaded with 0 on load.
  - Increments while transmitting.
  - shift is asserted when count == BAUD_DIV-1; the counter returns to 0 on that cycle.
- Bit counter (4 bits): cleared on load, incremented on each shift. The frame is complete when it reaches 10.
- State machine IDLE / TRANSMIT:
  - IDLE: if trmt, then load, clear tx_done, go to TRANSMIT. Otherwise hold; TX stays high.
  - TRANSMIT: count baud periods and shift. When bit_cnt == 10, set tx_done and return to IDLE.
  - Illegal/default state goes to IDLE.
- Timing:
  - trmt is sampled at edge k. TX goes low after edge k.
  - Each bit is held exactly BAUD_DIV cycles.
  - The stop bit starts at edge k + 9*BAUD_DIV.
  - tx_done rises at edge k + 10*BAUD_DIV, the same edge where the state returns to IDLE.
- trmt during TRANSMIT is ignored: no reload, and the frame in flight is not disturbed.
- Back-to-back: trmt in the first IDLE cycle after completion is accepted. Gap between frames is 0 extra bit times: the stop bit is followed directly by the next start bit.
- tx_done is cleared only by an accepted trmt (or by reset). It holds indefinitely otherwise.
- Reset mid-frame: TX returns high immediately (asynchronous), the frame is aborted, and tx_done = 0.
- tx_data may change freely after the load cycle.

Optional Feature:
- Macro: UART_TX_PARITY_EN
- When defined:
  - Frame is 11 bits: start, 8 data bits, even-parity bit (^tx_data, computed at load), stop.
  - Shift register is 10 bits and loads {^tx_data, tx_data, 1'b0}.
  - Done count is 11; tx_done rises at k + 11*BAUD_DIV.
- When undefined: 8N1 exactly as described above. The parity logic and extra register bit are absent.

Decomposition:
- Package uart_pkg:
  - Typedef tx_state_t enum logic {IDLE, TRANSMIT}.
  - Localparams FRAME_BITS (10, or 11 with parity) and BAUD_DIV_19200 = 2604.
  - The receiver may later import the same package.
- One natural sub-module: uart_baud_cnt. Inputs clk, rst_n, clr, en; output shift; parameter BAUD_DIV. It is reusable by the receiver with a half-period preload option.

Test Plan:
- Reset with trmt=0 -> TX=1 and tx_done=0, held for 5*BAUD_DIV cycles; no transitions on TX.
- BAUD_DIV=16, trmt with tx_data=8'hA5 -> TX sequence 0,1,0,1,0,0,1,0,1,1, each level exactly 16 cycles; tx_done rises at edge k+160.
- Frame in progress with tx_data=8'h3C, trmt pulsed again with 8'hFF at cycle k+40 -> waveform still encodes 8'h3C; tx_done rises once at k+160.
- Back-to-back 8'h00 then 8'hFF, trmt issued on the cycle after tx_done rises -> the stop bit of frame 1 is followed immediately by the start bit of frame 2; tx_done drops on the accept edge.
- rst_n asserted at k+70 mid-frame -> TX=1 asynchronously and tx_done=0; after release, a new trmt with 8'h55 transmits correctly.
- UART_TX_PARITY_EN defined, tx_data=8'h07 -> parity bit 1 appears at bits 9 (k+144..k+159); tx_done rises at k+176; loopback into the receiver (parity off) recovers 8'h07 for an 8'h07 frame in 8N1 mode.
